// File: rtl/serial_receiver.sv
// Receive side of the SIZE-bit serial link: gathers MSB-first chunks into a
// 32-bit word and reports completion with a hold-until-release handshake.
module serial_receiver #(
  parameter int SIZE = 1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [SIZE-1:0] Din,
  input  logic            DinValid,
  input  logic            StartRx,
  output logic [31:0]     DataOut,
  output logic            RxBusy,
  output logic            RxDone,
  output logic            Overrun
);
  localparam int N  = (32 + SIZE - 1) / SIZE;
  localparam int W  = N * SIZE;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RECEIVE, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    sh_q;
  logic [W-1:0]    sh_d;

  // With a single chunk per word the shift simply replaces the register.
  if (N == 1) begin : g_one
    assign sh_d = Din;
  end else begin : g_many
    assign sh_d = {sh_q[W-SIZE-1:0], Din};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      DataOut <= '0;
      RxBusy  <= 1'b0;
      RxDone  <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (StartRx) begin
            state_q <= RECEIVE;
            RxBusy  <= 1'b1;
            Overrun <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
          end
        end
        RECEIVE: begin
          // Abort takes priority over a final chunk arriving the same cycle.
          if (!StartRx) begin
            state_q <= IDLE;
            RxBusy  <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
          end else if (DinValid) begin
            sh_q <= sh_d;
            if (cnt_q == LAST) begin
              state_q <= DONE;
              DataOut <= sh_d[W-1 -: 32];
              RxBusy  <= 1'b0;
              RxDone  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (DinValid) Overrun <= 1'b1;
          if (!StartRx) begin
            state_q <= IDLE;
            RxDone  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver at several chunk widths side by side.
module tb_serial_receiver;
  localparam int NI = 5;

  function automatic int sz_of(int k);
    case (k)
      0: return 1;
      1: return 2;
      2: return 3;
      3: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int nch(int s);
    return (32 + s - 1) / s;
  endfunction

  logic        clk = 1'b0;
  logic [31:0] din  [NI];
  logic        dv   [NI];
  logic        srx  [NI];
  logic        rst  [NI];
  logic [31:0] dout [NI];
  logic        busy [NI];
  logic        done [NI];
  logic        ovr  [NI];

  logic [31:0] sbq  [NI][$];
  logic [31:0] last [NI];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int S = sz_of(g);
    serial_receiver #(.SIZE(S)) dut (
      .Clk(clk), .Reset(rst[g]), .Din(din[g][S-1:0]), .DinValid(dv[g]),
      .StartRx(srx[g]), .DataOut(dout[g]), .RxBusy(busy[g]),
      .RxDone(done[g]), .Overrun(ovr[g])
    );

    // Monitor: every completion must match the oldest outstanding word.
    initial begin
      logic pdone;
      logic [31:0] exp;
      pdone = 1'b0;
      forever begin
        @(negedge clk);
        if (done[g] && !pdone) begin
          if (sbq[g].size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_unexpected_done[%0d]: got DataOut=%h required no completion", g, dout[g]);
          end else begin
            exp = sbq[g].pop_front();
            chk($sformatf("sb_word[%0d]", g), dout[g], exp);
            chk($sformatf("sb_busy_at_done[%0d]", g), 32'(busy[g]), 32'd0);
          end
        end
        pdone = done[g];
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives nchunks chunks of word w (padded with pad, or random if pad<0),
  // with gmin..gmax idle cycles between chunks. Full words go to the scoreboard.
  task automatic send(int k, logic [31:0] w, int nchunks, int gmin, int gmax, int pad);
    int s = sz_of(k);
    int n = nch(s);
    int pb = n * s - 32;
    longint unsigned pm = (64'd1 << pb) - 64'd1;
    longint unsigned pv = (pad < 0) ? ({$urandom, $urandom} & pm) : (longint'(pad) & pm);
    longint unsigned full = ({32'h0, w} << pb) | pv;
    if (nchunks == n) sbq[k].push_back(w);
    for (int i = 0; i < nchunks; i++) begin
      din[k] = 32'((full >> (s * (n - 1 - i))) & ((64'd1 << s) - 64'd1));
      dv[k] = 1'b1;
      tick();
      dv[k] = 1'b0;
      if (i < n - 1) begin
        chk($sformatf("busy_mid[%0d]", k), 32'(busy[k]), 32'd1);
        chk($sformatf("done_early[%0d]", k), 32'(done[k]), 32'd0);
        if (i < nchunks - 1) begin
          repeat ($urandom_range(gmax, gmin)) begin
            tick();
            chk($sformatf("busy_gap[%0d]", k), 32'(busy[k]), 32'd1);
          end
        end
      end
    end
  endtask

  task automatic xfer(int k, logic [31:0] w, int gmin, int gmax, int pad);
    srx[k] = 1'b1;
    tick();
    chk($sformatf("busy_start[%0d]", k), 32'(busy[k]), 32'd1);
    send(k, w, nch(sz_of(k)), gmin, gmax, pad);
    last[k] = w;
    chk($sformatf("done_set[%0d]", k), 32'(done[k]), 32'd1);
    chk($sformatf("busy_clr[%0d]", k), 32'(busy[k]), 32'd0);
    tick();
    chk($sformatf("done_hold[%0d]", k), 32'(done[k]), 32'd1);
    srx[k] = 1'b0;
    tick();
    chk($sformatf("done_release[%0d]", k), 32'(done[k]), 32'd0);
    chk($sformatf("word_kept[%0d]", k), dout[k], last[k]);
  endtask

  task automatic abort_xfer(int k, int m);
    srx[k] = 1'b1;
    tick();
    send(k, $urandom, m, 0, 2, -1);
    srx[k] = 1'b0;
    tick();
    chk($sformatf("abort_busy[%0d]", k), 32'(busy[k]), 32'd0);
    chk($sformatf("abort_done[%0d]", k), 32'(done[k]), 32'd0);
    chk($sformatf("abort_data[%0d]", k), dout[k], last[k]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of run required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      din[k] = '0; dv[k] = 1'b0; srx[k] = 1'b0; rst[k] = 1'b1; last[k] = '0;
    end
    tick();
    tick();
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b0;
      chk($sformatf("rst_data[%0d]", k), dout[k], 32'h0);
      chk($sformatf("rst_busy[%0d]", k), 32'(busy[k]), 32'd0);
      chk($sformatf("rst_done[%0d]", k), 32'(done[k]), 32'd0);
      chk($sformatf("rst_ovr[%0d]", k), 32'(ovr[k]), 32'd0);
    end

    // SIZE=1 back-to-back, SIZE=4 with single idle gaps, SIZE=3 both paddings
    xfer(0, 32'hA5A50F0F, 0, 0, -1);
    xfer(3, 32'hDEADBEEF, 1, 1, -1);
    xfer(2, 32'h12345678, 0, 0, 0);
    xfer(2, 32'h12345678, 0, 0, 1);

    // SIZE=8 abort after two chunks, then a clean word
    xfer(4, 32'h11223344, 0, 1, -1);
    abort_xfer(4, 2);
    xfer(4, 32'hCAFEF00D, 0, 0, -1);

    // Overrun while holding DONE
    srx[4] = 1'b1;
    tick();
    send(4, 32'h0BADF00D, 4, 0, 0, -1);
    last[4] = 32'h0BADF00D;
    din[4] = 32'hFF; dv[4] = 1'b1;
    tick();
    dv[4] = 1'b0;
    chk("ovr_set", 32'(ovr[4]), 32'd1);
    chk("ovr_data", dout[4], 32'h0BADF00D);
    chk("ovr_done", 32'(done[4]), 32'd1);
    srx[4] = 1'b0;
    tick();
    srx[4] = 1'b1;
    tick();
    chk("ovr_clear", 32'(ovr[4]), 32'd0);
    chk("ovr_busy", 32'(busy[4]), 32'd1);
    srx[4] = 1'b0;
    tick();
    din[4] = 32'hFF; dv[4] = 1'b1;
    tick();
    dv[4] = 1'b0;
    chk("idle_dv_no_ovr", 32'(ovr[4]), 32'd0);
    chk("idle_dv_busy", 32'(busy[4]), 32'd0);

    // Abort coinciding with the final chunk
    srx[3] = 1'b1;
    tick();
    send(3, 32'h89ABCDEF, 7, 0, 0, -1);
    din[3] = 32'h5; dv[3] = 1'b1; srx[3] = 1'b0;
    tick();
    dv[3] = 1'b0;
    chk("abort_wins_done", 32'(done[3]), 32'd0);
    chk("abort_wins_busy", 32'(busy[3]), 32'd0);
    chk("abort_wins_data", dout[3], last[3]);

    // SIZE=2 reset mid-word
    xfer(1, 32'h5A5A1234, 0, 0, -1);
    srx[1] = 1'b1;
    tick();
    send(1, 32'hFFFFFFFF, 7, 0, 0, -1);
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0; srx[1] = 1'b0;
    last[1] = '0;
    chk("midrst_data", dout[1], 32'h0);
    chk("midrst_busy", 32'(busy[1]), 32'd0);
    chk("midrst_done", 32'(done[1]), 32'd0);
    chk("midrst_ovr", 32'(ovr[1]), 32'd0);
    tick();
    xfer(1, 32'h0123ABCD, 0, 0, -1);

    // Randomized traffic on every width, with occasional aborts
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NI; k++) begin
        if ($urandom_range(3, 0) == 0) abort_xfer(k, $urandom_range(nch(sz_of(k)) - 1, 1));
        xfer(k, $urandom, 0, $urandom_range(3, 0), -1);
      end
    end

    for (int k = 0; k < NI; k++) begin
      for (int t = 0; t < 20 && sbq[k].size() != 0; t++) tick();
      chk($sformatf("sb_drained[%0d]", k), sbq[k].size(), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_receiver.md
# serial_receiver

Receiving end of the team's SIZE-bit-wide serial link. Collects SIZE-bit chunks from the link MSB-first and reassembles the 32-bit word on a single clock. Reports completion to the control unit with a hold-until-release handshake that mirrors the transmit side. Sits between the serial link and the calculator's operand/result registers.

## Interface
- SIZE, 1, bits per chunk; legal range 1..32; need not divide 32.
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Din  input  SIZE  serial chunk; the most significant chunk arrives first.
- DinValid  input  1  Din holds a new chunk this cycle; one chunk per high cycle.
- StartRx  input  1  control-unit request to receive; held high for the whole transfer.
- DataOut  output  32  last completely received word.
- RxBusy  output  1  a word is being received.
- RxDone  output  1  a word has completed; held until StartRx goes low.
- Overrun  output  1  sticky error flag: a chunk arrived while DONE.

## Operation
- N = ceil(32/SIZE) chunks per word. The internal shift register is N*SIZE bits wide.
- Each accepted chunk updates the shift register as `sh <= {sh, Din}`, truncated to width, and adds 1 to the chunk counter.
- On completion, DataOut = sh[N*SIZE-1 : N*SIZE-32]. The low-order N*SIZE-32 bits of the final chunk are padding and are discarded.
- FSM states:
  - IDLE: RxBusy=0, RxDone=0.
    - StartRx=1 → RECEIVE.
    - On entry, the counter and sh are cleared and Overrun is cleared.
  - RECEIVE: RxBusy=1.
    - DinValid=1 accepts Din.
    - Accepting the N-th chunk → DONE, with DataOut loaded on the same edge.
    - StartRx=0 → abort to IDLE. The partial word is discarded and DataOut is unchanged.
    - If StartRx=0 and the N-th chunk arrive in the same cycle, the abort wins.
  - DONE: RxBusy=0, RxDone=1.
    - DinValid=1 sets Overrun; the chunk is ignored and DataOut is unchanged.
    - StartRx=0 → IDLE.
    - StartRx held high keeps the block in DONE. A new transfer needs StartRx low for at least one cycle.
- DinValid in IDLE is ignored and does not set Overrun.
- Reset, at any time including mid-word, forces IDLE. All outputs, the counter and sh go to 0.

## Timing
- Reset values: DataOut=0, RxBusy=0, RxDone=0, Overrun=0.
- StartRx sampled high at edge k in IDLE → RxBusy=1 after edge k. The first chunk is accepted at edge k+1 at the earliest.
- A chunk is accepted at the edge where DinValid=1 and the state is RECEIVE. Gaps in DinValid are allowed and have unlimited length.
- N-th chunk accepted at edge m → DataOut valid, RxDone=1 and RxBusy=0 after edge m. Back-to-back DinValid gives a minimum latency of N cycles from the first chunk.
- StartRx sampled low at edge d in DONE → RxDone=0 after edge d.
- Overrun is set after the edge on which it is detected. It stays high until the next IDLE→RECEIVE transition or Reset.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- SIZE=1: StartRx high, then 32 consecutive DinValid cycles carrying 0xA5A50F0F MSB-first → DataOut=0xA5A50F0F and RxDone=1 after the 32nd edge, RxBusy=0. Drop StartRx → RxDone=0 next cycle.
- SIZE=4: chunks D,E,A,D,B,E,E,F with one random idle cycle between each → DataOut=0xDEADBEEF after the 8th accepted chunk. RxBusy=1 throughout the gaps.
- SIZE=3: 11 chunks encode 0x12345678, with the last chunk = {bit1,bit0,0} → DataOut=0x12345678. Repeat with last-chunk padding bit=1 → DataOut still 0x12345678.
- SIZE=8: StartRx dropped after 2 of 4 chunks → IDLE and DataOut keeps the previous word. Then a full transfer of 0xCAFEF00D → DataOut=0xCAFEF00D, with no stale bytes from the aborted transfer.
- SIZE=8: after completion, hold StartRx high and pulse DinValid with Din=0xFF → Overrun=1 and DataOut unchanged. Release StartRx and restart → Overrun=0 after the IDLE→RECEIVE edge.
- SIZE=2: assert Reset after 7 chunks → all outputs 0 on the next cycle. Then 16 chunks of 0x0123ABCD → DataOut=0x0123ABCD.
